pool_layer_multi: RTL and testbench
===================================

POOL_LAYER_MULTI -- requirements
Module: pool_layer_multi

Interface
REQ-001 SHALL have parameter CH, default 6: number of feature-map channels.
REQ-002 SHALL have parameter IN_DIM, default 28: input map side; even.
REQ-003 SHALL have parameter DW, default 16: element width, IEEE-754 half precision.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  pulse requesting one pooling pass.
REQ-007 SHALL have port inputConv  input  CH*IN_DIM*IN_DIM*DW  conv-stage result, element i at bits [i*DW+:DW], i = c*IN_DIM^2 + r*IN_DIM + col.
REQ-008 SHALL have port outputPool  output  CH*(IN_DIM/2)^2*DW  pooled maps, element k = c*(IN_DIM/2)^2 + pr*(IN_DIM/2) + pc.
REQ-009 SHALL have port busy  output  1  high while a pass is running.
REQ-010 SHALL have port done  output  1  one-cycle pulse at pass completion.

Function
REQ-011 SHALL implement a 2x2, stride-2 max pool: window (c,pr,pc) covers input (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-012 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after last window; DONE->IDLE unconditionally next cycle.
REQ-013 SHALL process exactly one window per RUN cycle, in ascending k, via a window counter 0..NWIN-1, NWIN = CH*(IN_DIM/2)^2 (1176 at defaults).
REQ-014 SHALL write outputPool element k at the clock edge ending the RUN cycle in which the counter equals k.
REQ-015 SHALL assert busy exactly during RUN; start sampled at edge T gives busy in cycles T+1..T+NWIN, done high in cycle T+NWIN+1.
REQ-016 SHALL ignore start while in RUN or DONE; no restart, no queuing.
REQ-017 SHALL order FP16 values by total signed order: -0 < +0, negatives by descending magnitude; on equality, keep the earlier operand in window order.
REQ-018 SHALL treat inputs as non-NaN; NaN ordering is undefined.
REQ-019 SHALL require inputConv stable from the start edge until done; the block does not latch it.
REQ-020 SHALL keep outputPool elements not yet rewritten in a pass at their previous-pass values, and hold all elements stable in IDLE.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, force state IDLE, counter 0, busy 0, done 0, all outputPool bits 0.
REQ-022 SHALL give reset priority over start and abort a RUN pass mid-operation with no done pulse.

Configuration
REQ-023 SHALL honour macro POOL_RELU_EN: when defined, each pooled value with sign bit 1 (including -0) is written as 16'h0000; when undefined, the raw max is written.

Structure
REQ-024 SHALL place CH, IN_DIM, DW, OUT_DIM (=IN_DIM/2), NWIN and the FSM state encoding in shared package pool_pkg.
REQ-025 SHALL implement the two-input comparison of REQ-017 as combinational sub-module fp16_max2, instantiated three times as a tree.

Verification
REQ-026 SHALL cover: reset, start pulse, all inputs 16'h3C00 -> busy 1176 cycles, done one cycle later, every output 16'h3C00.
REQ-027 SHALL cover: window 0 inputs {3C00, 4000, BC00, 3800} -> outputPool[0] = 16'h4000; later windows unaffected.
REQ-028 SHALL cover: window all negatives {BC00, C000, B800, C400} -> 16'hB800 without POOL_RELU_EN, 16'h0000 with it.
REQ-029 SHALL cover: window {8000, 0000, 8000, 8000} -> 16'h0000; window all 8000 -> 16'h8000 without POOL_RELU_EN.
REQ-030 SHALL cover: reset asserted at RUN cycle 500 -> busy 0 next cycle, no done, outputPool all zero; a new start then completes normally.
REQ-031 SHALL cover: start re-pulsed at RUN cycle 10 and in the DONE cycle -> ignored; exactly one done, total RUN length 1176.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared configuration and FSM encoding for the 2x2 max-pool layer.
package pool_pkg;

    localparam int CH      = 6;
    localparam int IN_DIM  = 28;
    localparam int DW      = 16;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int NWIN    = CH * OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pool_layer_multi_fp16_max2.sv
// Combinational FP16 max under total signed order (-0 < +0); ties keep operand a.
module fp16_max2 #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_max
);

    logic [DW-1:0] w_key_a;
    logic [DW-1:0] w_key_b;

    // Map sign-magnitude onto an unsigned key: negatives invert, positives get the top bit set.
    assign w_key_a = i_a[DW-1] ? ~i_a : {1'b1, i_a[DW-2:0]};
    assign w_key_b = i_b[DW-1] ? ~i_b : {1'b1, i_b[DW-2:0]};

    assign o_max = (w_key_b > w_key_a) ? i_b : i_a;

endmodule

// File: rtl/pool_layer_multi.sv
// 2x2 stride-2 FP16 max pool, one window per cycle. Define POOL_RELU_EN to clamp
// negative (sign-bit set) pooled results to +0.
module pool_layer_multi #(
    parameter int CH     = pool_pkg::CH,
    parameter int IN_DIM = pool_pkg::IN_DIM,
    parameter int DW     = pool_pkg::DW
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CH*IN_DIM*IN_DIM*DW-1:0]   inputConv,
    output logic [CH*(IN_DIM/2)*(IN_DIM/2)*DW-1:0] outputPool,
    output logic                             busy,
    output logic                             done
);

    import pool_pkg::state_t;
    import pool_pkg::IDLE;
    import pool_pkg::RUN;
    import pool_pkg::DONE;

    localparam int L_OUT_DIM = IN_DIM / 2;
    localparam int L_NWIN    = CH * L_OUT_DIM * L_OUT_DIM;
    localparam int NIN       = CH * IN_DIM * IN_DIM;
    localparam int CW        = $clog2(L_NWIN);
    localparam int IW        = $clog2(NIN + 1);
    localparam int PW        = (L_OUT_DIM > 1) ? $clog2(L_OUT_DIM) : 1;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_win_cnt;
    logic [IW-1:0] r_base;
    logic [PW-1:0] r_pc;
    logic          w_last;
    logic          w_row_end;
    logic [DW-1:0] w_x [4];
    logic [DW-1:0] w_m0;
    logic [DW-1:0] w_m1;
    logic [DW-1:0] w_max;
    logic [DW-1:0] w_pooled;
    logic [DW-1:0] r_out [L_NWIN];

    assign w_last    = (r_win_cnt == CW'(L_NWIN - 1));
    assign w_row_end = (r_pc == PW'(L_OUT_DIM - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // r_base is the flat index of the window's top-left element; stepping past the
    // end of a pooled row (or channel) always advances it by IN_DIM+2.
    always_ff @(posedge clk) begin
        if (reset || r_state != RUN) begin
            r_win_cnt <= '0;
            r_base    <= '0;
            r_pc      <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_pc      <= w_row_end ? '0 : r_pc + 1'b1;
            r_base    <= r_base + (w_row_end ? IW'(IN_DIM + 2) : IW'(2));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            localparam int OFS = (gi / 2) * IN_DIM + (gi % 2);
            assign w_x[gi] = inputConv[(int'(r_base) + OFS) * DW +: DW];
        end
    endgenerate

    fp16_max2 #(.DW(DW)) u_max_top (.i_a(w_x[0]), .i_b(w_x[1]), .o_max(w_m0));
    fp16_max2 #(.DW(DW)) u_max_bot (.i_a(w_x[2]), .i_b(w_x[3]), .o_max(w_m1));
    fp16_max2 #(.DW(DW)) u_max_fin (.i_a(w_m0),   .i_b(w_m1),   .o_max(w_max));

`ifdef POOL_RELU_EN
    assign w_pooled = w_max[DW-1] ? '0 : w_max;
`else
    assign w_pooled = w_max;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L_NWIN; i++) begin
                r_out[i] <= '0;
            end
        end else if (r_state == RUN) begin
            r_out[r_win_cnt] <= w_pooled;
        end
    end

    generate
        for (gi = 0; gi < L_NWIN; gi++) begin : g_out
            assign outputPool[gi*DW +: DW] = r_out[gi];
        end
    endgenerate

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_pool_layer_multi.sv
// Scoreboard bench for pool_layer_multi: expected windows queued at stimulus time, checked at done.
module tb_pool_layer_multi;
    import pool_pkg::*;

    localparam int NIN = CH * IN_DIM * IN_DIM;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [NIN*DW-1:0]   inputConv;
    logic [NWIN*DW-1:0]  outputPool;
    logic                busy;
    logic                done;

    pool_layer_multi #(.CH(CH), .IN_DIM(IN_DIM), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .inputConv  (inputConv),
        .outputPool (outputPool),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // b strictly above a in sign-aware order, -0 below +0
    function automatic bit ref_gt(input logic [15:0] b, input logic [15:0] a);
        if (b[15] != a[15]) return !b[15];
        if (!b[15]) return b[14:0] > a[14:0];
        return b[14:0] < a[14:0];
    endfunction

    function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b);
        return ref_gt(b, a) ? b : a;
    endfunction

    function automatic logic [15:0] rand_h();
        logic [31:0] v;
        v = $urandom;
        if (v[14:10] == 5'h1F) v[14] = 1'b0;
        return v[15:0];
    endfunction

    function automatic int win_base(input int k);
        int c, pr, pc;
        c  = k / (OUT_DIM * OUT_DIM);
        pr = (k / OUT_DIM) % OUT_DIM;
        pc = k % OUT_DIM;
        return c * IN_DIM * IN_DIM + 2 * pr * IN_DIM + 2 * pc;
    endfunction

    task automatic plant(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        int base;
        base = win_base(k);
        inputConv[base*DW +: DW]              = a;
        inputConv[(base+1)*DW +: DW]          = b;
        inputConv[(base+IN_DIM)*DW +: DW]     = c;
        inputConv[(base+IN_DIM+1)*DW +: DW]   = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NIN; i++) inputConv[i*DW +: DW] = rand_h();
    endtask

    task automatic push_expected();
        int          base;
        logic [15:0] m;
        exp_t        e;
        for (int k = 0; k < NWIN; k++) begin
            base = win_base(k);
            m = ref_max(ref_max(inputConv[base*DW +: DW], inputConv[(base+1)*DW +: DW]),
                        ref_max(inputConv[(base+IN_DIM)*DW +: DW],
                                inputConv[(base+IN_DIM+1)*DW +: DW]));
`ifdef POOL_RELU_EN
            if (m[15]) m = 16'h0000;
`endif
            e.idx = k;
            e.val = m;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain_scoreboard(input string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("%s_out[%0d]", name, e.idx), 32'(outputPool[e.idx*DW +: DW]), 32'(e.val));
        end
    endtask

    // Runs one pass; start is re-pulsed at RUN cycle 10 and in the DONE cycle.
    // abort_at > 0 asserts reset during that RUN cycle instead of letting it finish.
    task automatic run_pass(input string name, input int abort_at);
        int cyc, busy_cnt, first_busy, done_cnt, done_cyc;
        bit aborted;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; first_busy = -1; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        while (cyc <= 1300) begin
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start = (busy && busy_cnt == 10) || done;
            if (abort_at > 0 && busy && busy_cnt == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq({name, "_abort_busy"}, 32'(busy), 32'd0);
                check_eq({name, "_abort_done"}, 32'(done), 32'd0);
                check_eq({name, "_abort_out_zero"}, 32'(|outputPool), 32'd0);
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            done_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || busy) done_cnt++;
            end
            check_eq({name, "_no_done_after_abort"}, 32'(done_cnt), 32'd0);
            $display("pass %s: aborted at RUN cycle %0d", name, abort_at);
        end else begin
            check_eq({name, "_first_busy_cyc"}, 32'(first_busy), 32'd1);
            check_eq({name, "_busy_cycles"}, 32'(busy_cnt), 32'(NWIN));
            check_eq({name, "_done_count"}, 32'(done_cnt), 32'd1);
            check_eq({name, "_done_cyc"}, 32'(done_cyc), 32'(NWIN + 1));
            drain_scoreboard(name);
            $display("pass %s: busy=%0d done_cyc=%0d", name, busy_cnt, done_cyc);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        inputConv = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_out_zero", 32'(|outputPool), 32'd0);
        $display("reset: busy=%0b done=%0b", busy, done);

        for (int i = 0; i < NIN; i++) inputConv[i*DW +: DW] = 16'h3C00;
        push_expected();
        run_pass("ones", 0);

        fill_random();
        plant(0, 16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
        plant(1, 16'hBC00, 16'hC000, 16'hB800, 16'hC400);
        plant(2, 16'h8000, 16'h0000, 16'h8000, 16'h8000);
        plant(3, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        plant(4, 16'h0000, 16'h8000, 16'h8000, 16'h8000);
        push_expected();
        run_pass("planted", 0);
        check_eq("w0_max", 32'(outputPool[0 +: DW]), 32'h4000);
`ifdef POOL_RELU_EN
        check_eq("w1_neg", 32'(outputPool[DW +: DW]), 32'h0000);
        check_eq("w3_negzero", 32'(outputPool[3*DW +: DW]), 32'h0000);
`else
        check_eq("w1_neg", 32'(outputPool[DW +: DW]), 32'hB800);
        check_eq("w3_negzero", 32'(outputPool[3*DW +: DW]), 32'h8000);
`endif
        check_eq("w2_poszero", 32'(outputPool[2*DW +: DW]), 32'h0000);

        fill_random();
        run_pass("abort", 500);

        fill_random();
        plant(NWIN - 1, 16'hBC00, 16'hC000, 16'hB800, 16'hC400);
        plant(NWIN - 2, 16'h0000, 16'h8000, 16'h8000, 16'h8000);
        push_expected();
        run_pass("after_abort", 0);

        push_expected();
        fill_random();
        repeat (20) @(negedge clk);
        drain_scoreboard("idle_hold");
        $display("idle hold: checked %0d outputs", NWIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
